// File: rtl/port_tx_if.sv
// ---------------------------------------------------------------------------
// port_tx_if -- FIFO-side and line-side signal bundle for the port_tx block.
//
//   ptr_fifo_empty  pointer FIFO empty flag            (queue manager -> tx)
//   ptr_fifo_rd     pointer FIFO read strobe           (tx -> queue manager)
//   ptr_fifo_dout   frame descriptor, [11:0] = length  (queue manager -> tx)
//   data_fifo_rd    data FIFO read strobe              (tx -> queue manager)
//   data_fifo_dout  data FIFO byte                     (queue manager -> tx)
//   tx_dv/tx_sof/tx_eof/tx_data  outgoing byte stream  (tx -> MAC)
//
// modport master : the transmit engine (port_tx)
// modport slave  : the environment (FIFOs + MAC)
// ---------------------------------------------------------------------------
interface port_tx_if;
  logic        ptr_fifo_empty;
  logic        ptr_fifo_rd;
  logic [15:0] ptr_fifo_dout;
  logic        data_fifo_rd;
  logic [7:0]  data_fifo_dout;
  logic        tx_dv;
  logic        tx_sof;
  logic        tx_eof;
  logic [7:0]  tx_data;

  modport master (
    input  ptr_fifo_empty, ptr_fifo_dout, data_fifo_dout,
    output ptr_fifo_rd, data_fifo_rd, tx_dv, tx_sof, tx_eof, tx_data
  );

  modport slave (
    output ptr_fifo_empty, ptr_fifo_dout, data_fifo_dout,
    input  ptr_fifo_rd, data_fifo_rd, tx_dv, tx_sof, tx_eof, tx_data
  );
endinterface

// File: rtl/port_tx.sv
// ---------------------------------------------------------------------------
// port_tx -- egress port transmit engine.
//
// Pops a frame descriptor from the pointer FIFO, then reads <len> bytes from
// the data FIFO and presents them as a contiguous tx_dv burst framed by
// tx_sof/tx_eof. An inter-frame gap of at least IFG cycles separates the last
// byte of one frame from the next pointer FIFO read.
//
// Ports
//   clk           clock, rising edge
//   rstn          asynchronous active-low reset
//   tx_en         high = a new frame may be started (sampled in IDLE only)
//   bus           port_tx_if.master (FIFO strobes/data, outgoing byte stream)
//   tx_frame_cnt  frames transmitted, wraps at 16 bits
//   busy          high whenever the engine is not IDLE
// ---------------------------------------------------------------------------
module port_tx #(
  parameter int IFG = 12
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         tx_en,
  port_tx_if.master    bus,
  output logic [15:0]  tx_frame_cnt,
  output logic         busy
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] PTR_RD  = 3'd1;
  localparam logic [2:0] PTR_LAT = 3'd2;
  localparam logic [2:0] DATA    = 3'd3;
  localparam logic [2:0] GAP     = 3'd4;

  // GAP lasts IFG cycles; combined with the two-cycle read-to-output latency
  // this places the next pointer read exactly IFG cycles after tx_eof.
  localparam logic [7:0] GAP_LOAD = 8'(IFG - 1);

  logic [2:0]  state_reg;
  logic        armed_reg;
  logic        ptr_rd_reg;
  logic        data_rd_reg;
  logic [11:0] len_cnt_reg;
  logic [7:0]  gap_cnt_reg;

  logic        rd_d1_reg;
  logic        tx_dv_reg;
  logic        tx_sof_reg;
  logic        tx_eof_reg;
  logic [7:0]  tx_data_reg;
  logic [15:0] frame_cnt_reg;

  // Descriptor bits [15:12] carry no meaning for this block.
  logic        unused_desc_bits;
  assign unused_desc_bits = ^bus.ptr_fifo_dout[15:12];

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= IDLE;
      armed_reg   <= 1'b0;
      ptr_rd_reg  <= 1'b0;
      data_rd_reg <= 1'b0;
      len_cnt_reg <= 12'd0;
      gap_cnt_reg <= 8'd0;
    end else begin
      // armed_reg holds off the first decision by one edge after reset
      // release, so the first pointer read lands on the second edge at best.
      armed_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (armed_reg && tx_en && !bus.ptr_fifo_empty) begin
            ptr_rd_reg <= 1'b1;
            state_reg  <= PTR_RD;
          end
        end
        PTR_RD: begin
          ptr_rd_reg <= 1'b0;
          state_reg  <= PTR_LAT;
        end
        PTR_LAT: begin
          // Descriptor is valid now (one-cycle FIFO latency).
          len_cnt_reg <= bus.ptr_fifo_dout[11:0];
          if (bus.ptr_fifo_dout[11:0] == 12'd0) begin
            state_reg <= IDLE;
          end else begin
            data_rd_reg <= 1'b1;
            state_reg   <= DATA;
          end
        end
        DATA: begin
          // data_rd_reg is high for every DATA cycle; len_cnt_reg counts
          // the reads still to be issued including the current one.
          if (len_cnt_reg == 12'd1) begin
            data_rd_reg <= 1'b0;
            len_cnt_reg <= 12'd0;
            gap_cnt_reg <= GAP_LOAD;
            state_reg   <= GAP;
          end else begin
            len_cnt_reg <= len_cnt_reg - 12'd1;
          end
        end
        GAP: begin
          if (gap_cnt_reg == 8'd0) begin
            state_reg <= IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - 8'd1;
          end
        end
        default: begin
          state_reg   <= IDLE;
          ptr_rd_reg  <= 1'b0;
          data_rd_reg <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output byte pipeline: read strobe at t, FIFO data at t+1, tx at t+2.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_d1_reg     <= 1'b0;
      tx_dv_reg     <= 1'b0;
      tx_sof_reg    <= 1'b0;
      tx_eof_reg    <= 1'b0;
      tx_data_reg   <= 8'h00;
      frame_cnt_reg <= 16'd0;
    end else begin
      rd_d1_reg   <= data_rd_reg;
      tx_dv_reg   <= rd_d1_reg;
      // Frames are always separated by idle cycles, so the first byte is the
      // one not preceded by a valid byte, and the last byte is the one whose
      // read is not followed by another read.
      tx_sof_reg  <= rd_d1_reg & ~tx_dv_reg;
      tx_eof_reg  <= rd_d1_reg & ~data_rd_reg;
      tx_data_reg <= rd_d1_reg ? bus.data_fifo_dout : 8'h00;
      if (tx_eof_reg) begin
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
    end
  end

  assign bus.ptr_fifo_rd  = ptr_rd_reg;
  assign bus.data_fifo_rd = data_rd_reg;
  assign bus.tx_dv        = tx_dv_reg;
  assign bus.tx_sof       = tx_sof_reg;
  assign bus.tx_eof       = tx_eof_reg;
  assign bus.tx_data      = tx_data_reg;
  assign tx_frame_cnt     = frame_cnt_reg;
  assign busy             = (state_reg != IDLE);

endmodule

// File: doc/port_tx.md
PORT_TX -- requirements
Module: port_tx

Interface
REQ-001 Parameter: IFG, default 12, minimum idle cycles from tx_eof to the next ptr_fifo_rd; legal range 1..255.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 tx_en  input  1  port enable from MAC/pause logic; high = new frames may start.
REQ-005 ptr_fifo_empty  input  1  queue-manager pointer FIFO empty flag.
REQ-006 ptr_fifo_rd  output  1  pointer FIFO read strobe, one-cycle pulse.
REQ-007 ptr_fifo_dout  input  16  frame descriptor; [11:0] = byte count held in data FIFO, [15:12] ignored.
REQ-008 data_fifo_rd  output  1  data FIFO read strobe.
REQ-009 data_fifo_dout  input  8  data FIFO read byte.
REQ-010 tx_dv  output  1  output byte valid.
REQ-011 tx_sof  output  1  first byte of frame, coincident with tx_dv.
REQ-012 tx_eof  output  1  last byte of frame, coincident with tx_dv.
REQ-013 tx_data  output  8  output byte.
REQ-014 tx_frame_cnt  output  16  frames transmitted, wraps 0xFFFF->0x0000.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 Both FIFOs SHALL be treated as having one-cycle read latency: dout valid the cycle after the rd strobe.
REQ-017 FSM states SHALL be IDLE, PTR_RD, PTR_LAT, DATA, GAP.
REQ-018 IDLE: if tx_en & !ptr_fifo_empty, assert ptr_fifo_rd this cycle (registered: ptr_fifo_rd high in the cycle after the decision, state PTR_RD); else stay.
REQ-019 PTR_RD -> PTR_LAT unconditionally; ptr_fifo_rd low.
REQ-020 PTR_LAT: latch len = ptr_fifo_dout[11:0]; len==0 -> descriptor discarded, no data read, no tx activity, tx_frame_cnt unchanged, go IDLE; else go DATA.
REQ-021 DATA: data_fifo_rd high for exactly len consecutive cycles (12-bit down-counter), then GAP.
REQ-022 tx_data/tx_dv SHALL be registered from data_fifo_dout: byte read with data_fifo_rd at cycle t appears on tx_data with tx_dv at t+2; tx_dv high for exactly len contiguous cycles.
REQ-023 tx_sof high on first tx_dv cycle only; tx_eof high on last tx_dv cycle only; len==1 -> tx_sof and tx_eof both high on the single cycle.
REQ-024 tx_frame_cnt SHALL increment by 1 in the cycle after tx_eof.
REQ-025 GAP: next ptr_fifo_rd SHALL occur no earlier than IFG cycles after the tx_eof cycle; then IDLE.
REQ-026 tx_en SHALL be sampled only in IDLE; deassertion during PTR_RD..GAP does not truncate or stall the current frame.
REQ-027 Max frame len 4095 SHALL transmit without counter overflow.
REQ-028 When idle, tx_data SHALL hold 0x00 and tx_sof/tx_eof/tx_dv SHALL be 0.

Reset
REQ-029 rstn low SHALL asynchronously force state IDLE and ptr_fifo_rd, data_fifo_rd, tx_dv, tx_sof, tx_eof, busy = 0, tx_data = 0x00, tx_frame_cnt = 0, len and counters = 0.
REQ-030 Reset mid-frame SHALL abort immediately with no further strobes; FIFO contents are not this block's responsibility.
REQ-031 After rstn rises, first ptr_fifo_rd SHALL be no earlier than the second rising clk edge.

Verification
REQ-032 Single frame: descriptor 0x0040, data bytes 0x00..0x3F, tx_en=1 -> 64 contiguous tx_dv cycles, bytes 0x00..0x3F, sof on 0x00, eof on 0x3F, tx_frame_cnt=1.
REQ-033 Back-to-back: two descriptors 0x0005, 0x0003 queued, IFG=12 -> second ptr_fifo_rd exactly 12 cycles after first tx_eof; both frames intact; count=2.
REQ-034 Boundaries: descriptor 0x0000 -> one ptr_fifo_rd, zero data_fifo_rd, no tx_dv, count unchanged; descriptor 0x0001 -> single cycle with sof=eof=1.
REQ-035 tx_en: tx_en=0 with non-empty ptr FIFO -> no strobes for 100 cycles; tx_en dropped mid-frame of len 100 -> all 100 bytes emitted, no new frame until tx_en=1.
REQ-036 Reset mid-frame: rstn low at byte 10 of a 50-byte frame -> all outputs 0 in same cycle (asynchronous), count=0, busy=0.
REQ-037 Max length: descriptor 0x0FFF -> exactly 4095 data_fifo_rd pulses and 4095 tx_dv cycles.
